// File: rtl/seq_shifter_if.sv
// Request/result handshake bundle for seq_shifter.
// The master drives the command side. The slave is the shifter engine.
interface seq_shifter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = $clog2(WIDTH) + 1
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [2:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             busy;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_carry, busy
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_carry, busy
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: shifts up to STEP bits per clock until the
// requested amount is consumed, then holds the result until it is taken.
module seq_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
  input logic          clk,
  input logic          rst,
  seq_shifter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [2:0] MODE_LSL = 3'b000;
  localparam logic [2:0] MODE_LSR = 3'b001;
  localparam logic [2:0] MODE_ASR = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  logic [1:0]       state, state_next;
  logic [WIDTH-1:0] work, work_next;
  logic [AMT_W-1:0] remaining, step_amt;
  logic [2:0]       mode;
  logic             carry, carry_next;
  logic             accept;
  logic             out_valid, out_carry;
  logic [WIDTH-1:0] out_data;

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_carry = out_carry;

  assign accept   = bus.in_valid && (state == IDLE);
  assign step_amt = (remaining < AMT_W'(STEP)) ? remaining : AMT_W'(STEP);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (remaining == '0) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Unrolled chain of single-bit steps; only the first step_amt take effect.
  always_comb begin
    work_next  = work;
    carry_next = carry;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (AMT_W'(i) < step_amt) begin
        case (mode)
          MODE_LSL: begin
            carry_next = work_next[WIDTH-1];
            work_next  = {work_next[WIDTH-2:0], 1'b0};
          end
          MODE_LSR: begin
            carry_next = work_next[0];
            work_next  = {1'b0, work_next[WIDTH-1:1]};
          end
          MODE_ASR: begin
            carry_next = work_next[0];
            work_next  = {work_next[WIDTH-1], work_next[WIDTH-1:1]};
          end
          MODE_ROL: begin
            carry_next = work_next[WIDTH-1];
            work_next  = {work_next[WIDTH-2:0], work_next[WIDTH-1]};
          end
          MODE_ROR: begin
            carry_next = work_next[0];
            work_next  = {work_next[0], work_next[WIDTH-1:1]};
          end
          default: ;
        endcase
      end
    end
  end

  // Reserved modes load a zero count so the operand passes straight through.
  always_ff @(posedge clk) begin
    if (rst) begin
      work      <= '0;
      mode      <= '0;
      remaining <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work      <= bus.in_data;
            mode      <= bus.in_mode;
            remaining <= (bus.in_mode > MODE_ROR) ? '0 : bus.in_amt;
            carry     <= 1'b0;
          end
        end
        SHIFT: begin
          if (remaining == '0) begin
            out_valid <= 1'b1;
            out_data  <= work;
            out_carry <= carry;
          end else begin
            work      <= work_next;
            carry     <= carry_next;
            remaining <= remaining - step_amt;
          end
        end
        DONE: begin
          if (bus.out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
